// File: rtl/alu_pkg.sv
// alu_iter shared types: op codes, FSM states and the single-cycle evaluator.
// Evaluator works on up to 64-bit operands and masks to the requested width.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_ADD = 3'b001,
    OP_SUB = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_SLL = 3'b101,
    OP_SLT = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [63:0] res;
    logic        carry;
    logic        ovf;
  } alu_res_t;

  // w must be a power of two in 4..64; MUL/NOP yield zero here
  function automatic alu_res_t alu_eval(
    input op_e         op,
    input logic [63:0] a_in,
    input logic [63:0] b_in,
    input int unsigned w
  );
    alu_res_t    r;
    logic [63:0] m;
    logic [63:0] a;
    logic [63:0] b;
    logic [64:0] s;
    logic [5:0]  msb;
    logic [6:0]  wi;
    logic [5:0]  sh;
    logic        sa;
    logic        sb;
    r   = '0;
    s   = '0;
    msb = 6'(w - 1);
    wi  = 7'(w);
    m   = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    a   = a_in & m;
    b   = b_in & m;
    sa  = a[msb];
    sb  = b[msb];
    sh  = 6'(b) & msb;
    unique case (1'b1)
      op == OP_ADD: begin
        s       = {1'b0, a} + {1'b0, b};
        r.res   = s[63:0] & m;
        r.carry = s[wi];
        r.ovf   = (sa == sb) && (r.res[msb] != sa);
      end
      op == OP_SUB: begin
        s       = {1'b0, a} - {1'b0, b};
        r.res   = s[63:0] & m;
        r.carry = a < b;
        r.ovf   = (sa != sb) && (r.res[msb] != sa);
      end
      op == OP_AND: r.res = a & b;
      op == OP_OR:  r.res = a | b;
      op == OP_SLL: r.res = (a << sh) & m;
      op == OP_SLT: r.res = 64'((sa != sb) ? sa : (a < b));
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier, one partial product per step.
// done flags the final step; prod is the accumulator value after this step.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mc;
  logic [WIDTH-1:0]   mp;
  logic [CW-1:0]      cnt;

  assign prod = acc + (mp[0] ? mc : '0);
  assign done = step && (cnt == CW'(WIDTH - 1));

  // load operands on start, then shift and accumulate per step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      mc  <= '0;
      mp  <= '0;
      cnt <= '0;
    end else if (start) begin
      acc <= '0;
      mc  <= {{WIDTH{1'b0}}, a};
      mp  <= b;
      cnt <= '0;
    end else if (step) begin
      acc <= prod;
      mc  <= mc << 1;
      mp  <= mp >> 1;
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/alu_iter.sv
// Sequential ALU with valid/ready operand and result handshakes.
// Define ALU_MUL_EN to enable the iterative multiply on op 111.
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf,
  output logic             busy
);

  state_e           st;
  state_e           st_n;
  alu_res_t         ev;
  logic             ld;
  logic [WIDTH-1:0] res_n;
  logic             cy_n;
  logic             ov_n;
  logic             unused_ev;

  assign ev        = alu_eval(op_e'(op), 64'(a), 64'(b), WIDTH);
  assign unused_ev = ^ev.res;
  assign in_ready  = (st == S_IDLE);
  assign out_valid = (st == S_DONE);
  assign busy      = (st != S_IDLE);

`ifdef ALU_MUL_EN
  logic               mul_start;
  logic               mul_step;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  assign mul_step = (st == S_CALC);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (reset),
    .start (mul_start),
    .step  (mul_step),
    .a     (a),
    .b     (b),
    .done  (mul_done),
    .prod  (mul_prod)
  );
`endif

  // next state and result load decode
  always_comb begin
    st_n  = st;
    ld    = 1'b0;
    res_n = '0;
    cy_n  = 1'b0;
    ov_n  = 1'b0;
`ifdef ALU_MUL_EN
    mul_start = 1'b0;
`endif
    unique case (st)
      S_IDLE: begin
        if (in_valid) begin
`ifdef ALU_MUL_EN
          if (op == OP_MUL) begin
            st_n      = S_CALC;
            mul_start = 1'b1;
          end else
`endif
          begin
            st_n  = S_DONE;
            ld    = 1'b1;
            res_n = ev.res[WIDTH-1:0];
            cy_n  = ev.carry;
            ov_n  = ev.ovf;
          end
        end
      end
      S_CALC: begin
`ifdef ALU_MUL_EN
        if (mul_done) begin
          st_n  = S_DONE;
          ld    = 1'b1;
          res_n = mul_prod[WIDTH-1:0];
          cy_n  = |mul_prod[2*WIDTH-1:WIDTH];
        end
`else
        st_n = S_IDLE;
`endif
      end
      S_DONE: begin
        if (out_ready) st_n = S_IDLE;
      end
      default: st_n = S_IDLE;
    endcase
  end

  // state register; result and flags only move on entry to DONE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st         <= S_IDLE;
      result     <= '0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
      flag_ovf   <= 1'b0;
    end else begin
      st <= st_n;
      if (ld) begin
        result     <= res_n;
        flag_zero  <= (res_n == '0);
        flag_carry <= cy_n;
        flag_ovf   <= ov_n;
      end
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Testbench for alu_iter (WIDTH 8) with a behavioural reference model.
// Expectations for op 111 follow ALU_MUL_EN as seen by this compile.
module tb_alu_iter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] op = 3'd0;
  logic [7:0] a = 8'd0;
  logic [7:0] b = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] result;
  logic       flag_zero;
  logic       flag_carry;
  logic       flag_ovf;
  logic       busy;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_iter #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .flag_ovf   (flag_ovf),
    .busy       (busy)
  );

`ifdef ALU_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  function automatic int sx(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  // reference: plain integer arithmetic on 8-bit values
  function automatic void model(
    input int o, input int x, input int y,
    output int r, output int c, output int v, output int lat
  );
    int t;
    r = 0; c = 0; v = 0; lat = 1;
    case (o)
      1: begin
        t = x + y; r = t % 256; c = (t > 255);
        t = sx(x) + sx(y); v = (t > 127 || t < -128);
      end
      2: begin
        r = (x - y + 256) % 256; c = (x < y);
        t = sx(x) - sx(y); v = (t > 127 || t < -128);
      end
      3: r = x & y;
      4: r = x | y;
      5: r = (x * (1 << (y % 8))) % 256;
      6: r = (sx(x) < sx(y)) ? 1 : 0;
      7: if (MUL_ON) begin
        t = x * y; r = t % 256; c = (t > 255); lat = 9;
      end
      default: r = 0;
    endcase
  endfunction

  task automatic run_op(
    input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
    output logic [7:0] r, output logic [2:0] f, output int lat
  );
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    r = result;
    f = {flag_zero, flag_carry, flag_ovf};
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic check_op(input string nm, input logic [2:0] o,
                          input logic [7:0] x, input logic [7:0] y);
    logic [7:0] r;
    logic [2:0] f;
    int lat, er, ec, ev, el;
    model(o, x, y, er, ec, ev, el);
    run_op(o, x, y, r, f, lat);
    n_chk++;
    if (r !== 8'(er)) begin
      n_fail++;
      $display("FAIL %s result op=%0d a=%h b=%h got %h want %h",
               nm, o, x, y, r, 8'(er));
    end
    n_chk++;
    if (f !== {er == 0, ec[0], ev[0]}) begin
      n_fail++;
      $display("FAIL %s flags(z,c,v) op=%0d a=%h b=%h got %b want %b",
               nm, o, x, y, f, {er == 0, ec[0], ev[0]});
    end
    n_chk++;
    if (lat != el) begin
      n_fail++;
      $display("FAIL %s latency op=%0d got %0d want %0d", nm, o, lat, el);
    end
    drain();
    n_chk++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      n_fail++;
      $display("FAIL %s post-drain (ov,ir,busy) got %b want 010",
               nm, {out_valid, in_ready, busy});
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    n_chk++;
    if ({out_valid, busy, in_ready, result, flag_zero, flag_carry, flag_ovf}
        !== {1'b0, 1'b0, 1'b1, 8'h00, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_state got ov=%b busy=%b ir=%b res=%h z%b c%b v%b",
               out_valid, busy, in_ready, result,
               flag_zero, flag_carry, flag_ovf);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_directed();
    logic [7:0] r;
    logic [2:0] f;
    int lat;
    // ADD overflow, literal expectations
    run_op(3'd1, 8'h7F, 8'h01, r, f, lat);
    n_chk++;
    if ({r, f} !== {8'h80, 3'b001} || lat != 1) begin
      n_fail++;
      $display("FAIL add_7f_01 got %h zcv=%b lat=%0d want 80 001 lat 1",
               r, f, lat);
    end
    drain();
    run_op(3'd2, 8'h01, 8'h02, r, f, lat);
    n_chk++;
    if ({r, f} !== {8'hFF, 3'b010}) begin
      n_fail++;
      $display("FAIL sub_01_02 got %h zcv=%b want ff 010", r, f);
    end
    drain();
    run_op(3'd6, 8'h80, 8'h01, r, f, lat);
    n_chk++;
    if (r !== 8'h01) begin
      n_fail++;
      $display("FAIL slt_80_01 got %h want 01", r);
    end
    drain();
    run_op(3'd5, 8'h01, 8'h0B, r, f, lat);
    n_chk++;
    if (r !== 8'h08) begin
      n_fail++;
      $display("FAIL sll_01_0b got %h want 08", r);
    end
    drain();
    check_op("mul_0f_11", 3'd7, 8'h0F, 8'h11);
    check_op("mul_10_10", 3'd7, 8'h10, 8'h10);
    check_op("op7_05_07", 3'd7, 8'h05, 8'h07);
    check_op("nop", 3'd0, 8'hA5, 8'h5A);
    check_op("sub_eq", 3'd2, 8'h33, 8'h33);
    check_op("add_ff_01", 3'd1, 8'hFF, 8'h01);
    check_op("sub_80_01", 3'd2, 8'h80, 8'h01);
    check_op("sll_max", 3'd5, 8'h81, 8'h07);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++)
      check_op("random", 3'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic test_backpressure();
    logic [7:0] r;
    logic [2:0] f;
    int lat;
    run_op(3'd2, 8'h10, 8'h20, r, f, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom);
      op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
      @(posedge clk); #1;
      n_chk++;
      if ({result, flag_zero, flag_carry, flag_ovf, out_valid, in_ready}
          !== {8'hF0, 3'b010, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL backpressure cyc%0d res=%h zcv=%b%b%b ov=%b ir=%b",
                 i, result, flag_zero, flag_carry, flag_ovf,
                 out_valid, in_ready);
      end
    end
    in_valid = 1'b0;
    drain();
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_exit ov=%b ir=%b want 0 1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] r;
    logic [2:0] f;
    int lat;
    run_op(3'd1, 8'h11, 8'h22, r, f, lat);
    op = 3'd3; a = 8'hF0; b = 8'h3C;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_idle ov=%b ir=%b want 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_chk++;
    if (out_valid !== 1'b1 || result !== 8'h30) begin
      n_fail++;
      $display("FAIL b2b_second ov=%b res=%h want 1 30", out_valid, result);
    end
    drain();
  endtask

  task automatic test_reset_mid_mul();
    @(negedge clk);
    op = 3'd7; a = 8'h0F; b = 8'h11; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_mul_busy got %b want 1", busy);
    end
    reset = 1'b0;
    #1;
    n_chk++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL reset_mid_mul (ov,busy,ir) got %b want 001",
               {out_valid, busy, in_ready});
    end
    #1;
    reset = 1'b1;
    check_op("add_after_reset", 3'd1, 8'h02, 8'h03);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_mul();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
